// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Programmable VGA raster timing generator. A clock-enable divider produces
//   one pixel tick every CLK_DIV system clocks. The horizontal and vertical
//   counters advance on each tick. All raster outputs are registered from the
//   same next-pixel values, so they always describe the same pixel.
//   Timing values are written into staging registers through a valid/ready
//   port. A commit makes them live at the next frame wrap, but only if the
//   staged set is consistent.
//
// Ports
//   i_clk, i_rst_n       system clock, asynchronous active-low reset
//   i_cfg_valid/o_cfg_ready/i_cfg_addr/i_cfg_data
//                        config write port; addr 0..7 selects a timing
//                        register (HRES, HSRT, HEND, HTOT, VRES, VSRT, VEND,
//                        VTOT), addr 8 commits, and addr 9..15 is accepted
//                        and ignored
//   o_cfg_err            sticky: the last commit was rejected
//   o_pix_tick           one-clock pixel enable
//   o_hsync, o_vsync     active-low syncs
//   o_blank              high outside the active area
//   o_x, o_y             coordinates of the pixel currently presented
//   o_frame_start        one-clock pulse when (0,0) is presented
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned HRES    = 640,
  parameter int unsigned HSRT    = 656,
  parameter int unsigned HEND    = 752,
  parameter int unsigned HTOT    = 800,
  parameter int unsigned VRES    = 480,
  parameter int unsigned VSRT    = 490,
  parameter int unsigned VEND    = 492,
  parameter int unsigned VTOT    = 525
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [3:0]  i_cfg_addr,
  input  logic [11:0] i_cfg_data,
  output logic        o_cfg_err,
  output logic        o_pix_tick,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start
);

  localparam int unsigned I_HRES = 0;
  localparam int unsigned I_HSRT = 1;
  localparam int unsigned I_HEND = 2;
  localparam int unsigned I_HTOT = 3;
  localparam int unsigned I_VRES = 4;
  localparam int unsigned I_VSRT = 5;
  localparam int unsigned I_VEND = 6;
  localparam int unsigned I_VTOT = 7;

  localparam logic [11:0] DEFAULTS [8] = '{
    12'(HRES), 12'(HSRT), 12'(HEND), 12'(HTOT),
    12'(VRES), 12'(VSRT), 12'(VEND), 12'(VTOT)
  };

  localparam logic [3:0] DIV_LAST    = 4'(CLK_DIV - 1);
  localparam logic [3:0] ADDR_COMMIT = 4'd8;

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } state_t;

  state_t state_q, state_d;

  logic [11:0] live_q  [8];
  logic [11:0] stage_q [8];
  logic [11:0] live_d  [8];

  logic [3:0]  div_q, div_d;
  logic        tick;
  logic        run_q;
  logic [11:0] hcnt_q, vcnt_q;
  logic [11:0] hcnt_d, vcnt_d;
  logic        h_wrap, v_wrap, frame_wrap;

  logic        cfg_xfer, wr_stage, wr_commit;
  logic        stage_ok;
  logic        apply, reject;

  logic        hsync_d, vsync_d, blank_d, fstart_d;

  // Divider and handshake decode
  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 4'd1;
    cfg_xfer  = i_cfg_valid && o_cfg_ready;
    wr_stage  = cfg_xfer && !i_cfg_addr[3];
    wr_commit = cfg_xfer && (i_cfg_addr == ADDR_COMMIT);
  end

  // Staged set must describe a well-ordered raster in both axes
  always_comb begin
    stage_ok = (stage_q[I_HRES] != '0) &&
               (stage_q[I_HRES] <  stage_q[I_HSRT]) &&
               (stage_q[I_HSRT] <  stage_q[I_HEND]) &&
               (stage_q[I_HEND] <= stage_q[I_HTOT]) &&
               (stage_q[I_VRES] != '0) &&
               (stage_q[I_VRES] <  stage_q[I_VSRT]) &&
               (stage_q[I_VSRT] <  stage_q[I_VEND]) &&
               (stage_q[I_VEND] <= stage_q[I_VTOT]);
  end

  // Counter next-state. hcnt/vcnt hold the pixel on the outputs. The
  // first tick after reset presents (0,0) instead of advancing, so
  // o_frame_start fires for the first frame too.
  always_comb begin
    h_wrap     = hcnt_q >= (live_q[I_HTOT] - 12'd1);
    v_wrap     = vcnt_q >= (live_q[I_VTOT] - 12'd1);
    frame_wrap = run_q && h_wrap && v_wrap;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    if (!run_q) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_wrap) begin
      hcnt_d = '0;
      vcnt_d = v_wrap ? '0 : vcnt_q + 12'd1;
    end else begin
      hcnt_d = hcnt_q + 12'd1;
    end
  end

  // Commit FSM
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_commit) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (tick && frame_wrap) begin
          apply   = stage_ok;
          reject  = !stage_ok;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pixel presented at the wrap is decoded with the incoming live set.
  // This makes the new frame use the new values from (0,0) onward.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      live_d[i] = apply ? stage_q[i] : live_q[i];
    end
    hsync_d  = !((hcnt_d >= live_d[I_HSRT]) && (hcnt_d < live_d[I_HEND]));
    vsync_d  = !((vcnt_d >= live_d[I_VSRT]) && (vcnt_d < live_d[I_VEND]));
    blank_d  = (hcnt_d >= live_d[I_HRES]) || (vcnt_d >= live_d[I_VRES]);
    fstart_d = (hcnt_d == '0) && (vcnt_d == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q         <= '0;
      run_q         <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      o_pix_tick    <= 1'b0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_blank       <= 1'b1;
      o_frame_start <= 1'b0;
      o_cfg_ready   <= 1'b1;
      o_cfg_err     <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        live_q[i]  <= DEFAULTS[i];
        stage_q[i] <= DEFAULTS[i];
      end
    end else begin
      div_q      <= div_d;
      o_pix_tick <= (div_d == DIV_LAST);

      if (tick) begin
        run_q         <= 1'b1;
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        o_hsync       <= hsync_d;
        o_vsync       <= vsync_d;
        o_blank       <= blank_d;
        o_frame_start <= fstart_d;
      end else begin
        o_frame_start <= 1'b0;
      end

      for (int unsigned i = 0; i < 8; i++) begin
        live_q[i] <= live_d[i];
      end
      if (wr_stage) begin
        stage_q[i_cfg_addr[2:0]] <= i_cfg_data;
      end

      if (wr_stage) begin
        o_cfg_err <= 1'b0;
      end else if (reject) begin
        o_cfg_err <= 1'b1;
      end else if (apply) begin
        o_cfg_err <= 1'b0;
      end

      o_cfg_ready <= (state_d == S_IDLE);
    end
  end

  assign o_x = hcnt_q;
  assign o_y = vcnt_q;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Programmable VGA raster timing controller. Runs from one system clock with an internal pixel-clock enable divider.
- Produces hsync, vsync and blank plus the current pixel coordinates, which drive the pixel-colour datapath.
- Timing values are written at runtime through a valid/ready config port into staging registers.
- Staged values go live only at a frame boundary, so a frame is never torn.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (allowed range 1..15).
- HRES, 640, active pixels per line.
- HSRT, 656, hsync assert column.
- HEND, 752, hsync deassert column.
- HTOT, 800, total columns per line.
- VRES, 480, active lines per frame.
- VSRT, 490, vsync assert line.
- VEND, 492, vsync deassert line.
- VTOT, 525, total lines per frame.

Ports:
- i_clk  in  1  system clock (50 MHz)
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_cfg_valid  in  1  config write request
- o_cfg_ready  out  1  config port can accept a write
- i_cfg_addr  in  4  0..7 = HRES, HSRT, HEND, HTOT, VRES, VSRT, VEND, VTOT; 8 = commit
- i_cfg_data  in  12  value to write (ignored for commit)
- o_cfg_err  out  1  sticky flag: last commit was rejected
- o_pix_tick  out  1  one-clock pulse per pixel
- o_hsync  out  1  horizontal sync, active-low
- o_vsync  out  1  vertical sync, active-low
- o_blank  out  1  high outside the active area
- o_x  out  12  current column
- o_y  out  12  current line
- o_frame_start  out  1  one-clock pulse at pixel (0,0)

Behaviour:
- Reset values: hsync=1, vsync=1, blank=1, x=0, y=0, pix_tick=0, frame_start=0, cfg_ready=1, cfg_err=0.
- Reset loads the live and staging registers from the parameters and clears the divider and both counters. Reset mid-operation aborts any pending commit.
- Divider counts 0..CLK_DIV-1. o_pix_tick is high in the cycle where the divider equals CLK_DIV-1.
- Counters advance only on a tick. hcnt wraps at HTOT-1 to 0. On that wrap vcnt increments, and vcnt wraps at VTOT-1 to 0.
- All outputs are registered and describe the same pixel in the same cycle; there is no relative skew between them.
- o_x=hcnt and o_y=vcnt at all times, including during blanking.
- o_hsync=0 iff HSRT<=hcnt<HEND. o_vsync=0 iff VSRT<=vcnt<VEND. Comparisons use live registers.
- o_blank=1 iff hcnt>=HRES or vcnt>=VRES.
- o_frame_start=1 for exactly one clock, the cycle in which the outputs first present (0,0).
- Config handshake: a transfer happens when valid && ready are both high in a cycle.
  - Addr 0..7 writes the staging register and clears o_cfg_err.
  - Addr 9..15: transfer accepted, no effect.
  - Addr 8 (commit) sets pending and drops o_cfg_ready in the next cycle.
- FSM, states IDLE, PENDING:
  - IDLE→PENDING on a commit transfer.
  - In PENDING, on the tick where hcnt=HTOT-1 and vcnt=VTOT-1, the staging set is validated.
  - Validation rule: 0<HRES<HSRT<HEND<=HTOT and 0<VRES<VSRT<VEND<=VTOT.
  - If valid, staging is copied to live and the counters wrap to 0 under the new values, so the frame starting at (0,0) uses them.
  - If invalid, live registers are unchanged and o_cfg_err=1.
  - Either way, return to IDLE and o_cfg_ready=1 the next cycle.
- Writes are not accepted while PENDING (ready=0).
- If live values are shrunk so that a counter exceeds its total, the counter wraps at >=TOT-1. This cannot occur via commit, because commit happens only at the wrap.
- No arithmetic overflow: the 12-bit compares are unsigned, and the maximum total is 4095.

Test Plan:
- Reset, then run 2 full frames → first frame_start at clock CLK_DIV*1 after reset release; frame period 800*525*2 = 840000 clocks; hsync low for 96 ticks per line; vsync low for 2 lines; blank low exactly for x<640, y<480.
- Check o_x/o_y → count 0..799 and 0..524 with wrap; o_pix_tick high every 2nd clock.
- Write HRES=320, HSRT=328, HEND=376, HTOT=400, then commit mid-frame → ready low until the frame end; the current frame keeps 800-wide lines; the next frame has 400-tick lines; o_cfg_err=0.
- Write HSRT=900 with HTOT=800, then commit → at the frame end err=1; timing unchanged; the next write to addr 0 clears err.
- Assert i_cfg_valid while PENDING → no transfer; staging unchanged; a second commit is not queued.
- Drop i_rst_n mid-line and mid-pending → outputs take reset values asynchronously; after release, timing is back to the parameter defaults and ready=1.
